// File: rtl/mult_div_unit.sv
// Iterative 32-bit multiply/divide unit: shift-add multiply and restoring divide,
// 32 iterations plus a sign-fix cycle, result held in registered HI/LO.
module mult_div_unit (
   input  logic        clock,
   input  logic        reset_n,
   input  logic        start,
   input  logic [1:0]  op,
   input  logic [31:0] a,
   input  logic [31:0] b,
   output logic        busy,
   output logic        done,
   output logic [31:0] hi,
   output logic [31:0] lo
);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_CALC = 2'd1,
      S_FIX  = 2'd2,
      S_DONE = 2'd3
   } state_t;

   function automatic logic [31:0] neg32(input logic [31:0] v);
      return (~v) + 32'd1;
   endfunction

   function automatic logic [63:0] neg64(input logic [63:0] v);
      return (~v) + 64'd1;
   endfunction

   state_t      state_q, state_d;
   logic        busy_q, busy_d;
   logic        done_q, done_d;
   logic [31:0] hi_q, hi_d;
   logic [31:0] lo_q, lo_d;
   logic [4:0]  cnt_q, cnt_d;
   logic        is_div_q, is_div_d;
   logic        sign_q, sign_d;
   logic        rsign_q, rsign_d;
   logic        dz_q, dz_d;
   logic [31:0] a_raw_q, a_raw_d;
   logic [31:0] opnd_q, opnd_d;
   logic [63:0] acc_q, acc_d;

   logic        signed_op_s;
   logic [31:0] a_mag_s;
   logic [31:0] b_mag_s;
   logic [32:0] mul_sum_s;
   logic [32:0] rem_sh_s;
   logic [32:0] trial_s;
   logic        ge_s;
   logic [63:0] mul_step_s;
   logic [63:0] div_step_s;
   logic [63:0] prod_fix_s;
   logic [31:0] quo_fix_s;
   logic [31:0] rem_fix_s;

   assign signed_op_s = ~op[0];
   assign a_mag_s     = (signed_op_s && a[31]) ? neg32(a) : a;
   assign b_mag_s     = (signed_op_s && b[31]) ? neg32(b) : b;

   // Multiply step: conditionally add multiplicand to the upper half, then shift right.
   assign mul_sum_s  = acc_q[0] ? ({1'b0, acc_q[63:32]} + {1'b0, opnd_q})
                                : {1'b0, acc_q[63:32]};
   assign mul_step_s = {mul_sum_s, acc_q[31:1]};

   // Restoring step: the shifted remainder can reach 33 bits, so compare on 33 bits.
   assign rem_sh_s   = acc_q[63:31];
   assign trial_s    = rem_sh_s - {1'b0, opnd_q};
   assign ge_s       = rem_sh_s[32] | ~trial_s[32];
   assign div_step_s = ge_s ? {trial_s[31:0], acc_q[30:0], 1'b1}
                            : {rem_sh_s[31:0], acc_q[30:0], 1'b0};

   assign prod_fix_s = sign_q  ? neg64(acc_q)        : acc_q;
   assign quo_fix_s  = sign_q  ? neg32(acc_q[31:0])  : acc_q[31:0];
   assign rem_fix_s  = rsign_q ? neg32(acc_q[63:32]) : acc_q[63:32];

   // Next-state and datapath selection for the whole unit.
   always_comb begin
      state_d  = state_q;
      busy_d   = busy_q;
      done_d   = 1'b0;
      hi_d     = hi_q;
      lo_d     = lo_q;
      cnt_d    = cnt_q;
      is_div_d = is_div_q;
      sign_d   = sign_q;
      rsign_d  = rsign_q;
      dz_d     = dz_q;
      a_raw_d  = a_raw_q;
      opnd_d   = opnd_q;
      acc_d    = acc_q;
      case (state_q)
         S_IDLE, S_DONE: begin
            if (start) begin
               is_div_d = op[1];
               sign_d   = signed_op_s & (a[31] ^ b[31]);
               rsign_d  = signed_op_s & a[31];
               dz_d     = (b == 32'd0);
               a_raw_d  = a;
               opnd_d   = op[1] ? b_mag_s : a_mag_s;
               acc_d    = {32'd0, (op[1] ? a_mag_s : b_mag_s)};
               cnt_d    = 5'd0;
               busy_d   = 1'b1;
               state_d  = S_CALC;
            end else begin
               busy_d   = 1'b0;
               state_d  = S_IDLE;
            end
         end
         S_CALC: begin
            acc_d = is_div_q ? div_step_s : mul_step_s;
            cnt_d = cnt_q + 5'd1;
            if (cnt_q == 5'd31) begin
               state_d = S_FIX;
            end else begin
               state_d = S_CALC;
            end
         end
         S_FIX: begin
            if (!is_div_q) begin
               hi_d = prod_fix_s[63:32];
               lo_d = prod_fix_s[31:0];
            end else if (dz_q) begin
               hi_d = a_raw_q;
               lo_d = 32'hFFFF_FFFF;
            end else begin
               hi_d = rem_fix_s;
               lo_d = quo_fix_s;
            end
            done_d  = 1'b1;
            busy_d  = 1'b0;
            state_d = S_DONE;
         end
         default: begin
            busy_d  = 1'b0;
            state_d = S_IDLE;
         end
      endcase
   end

   // State and result registers; reset discards any in-flight operation.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state_q  <= S_IDLE;
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
         hi_q     <= 32'd0;
         lo_q     <= 32'd0;
         cnt_q    <= 5'd0;
         is_div_q <= 1'b0;
         sign_q   <= 1'b0;
         rsign_q  <= 1'b0;
         dz_q     <= 1'b0;
         a_raw_q  <= 32'd0;
         opnd_q   <= 32'd0;
         acc_q    <= 64'd0;
      end else begin
         state_q  <= state_d;
         busy_q   <= busy_d;
         done_q   <= done_d;
         hi_q     <= hi_d;
         lo_q     <= lo_d;
         cnt_q    <= cnt_d;
         is_div_q <= is_div_d;
         sign_q   <= sign_d;
         rsign_q  <= rsign_d;
         dz_q     <= dz_d;
         a_raw_q  <= a_raw_d;
         opnd_q   <= opnd_d;
         acc_q    <= acc_d;
      end
   end

   assign busy = busy_q;
   assign done = done_q;
   assign hi   = hi_q;
   assign lo   = lo_q;

endmodule

// File: tb/tb_mult_div_unit.sv
// Scoreboard bench for mult_div_unit: directed vectors push expected HI/LO and
// completion cycle; a negedge monitor pops and compares on every done pulse.
module tb_mult_div_unit;

   logic        clock;
   logic        reset_n;
   logic        start;
   logic [1:0]  op;
   logic [31:0] a;
   logic [31:0] b;
   logic        busy;
   logic        done;
   logic [31:0] hi;
   logic [31:0] lo;

   localparam logic [1:0] OP_MULT  = 2'b00;
   localparam logic [1:0] OP_MULTU = 2'b01;
   localparam logic [1:0] OP_DIV   = 2'b10;
   localparam logic [1:0] OP_DIVU  = 2'b11;

   typedef struct {
      logic [31:0] hi;
      logic [31:0] lo;
      int          due;
   } exp_t;

   exp_t sb[$];
   int   cyc;
   int   checks;
   int   errors;

   mult_div_unit dut (
      .clock   (clock),
      .reset_n (reset_n),
      .start   (start),
      .op      (op),
      .a       (a),
      .b       (b),
      .busy    (busy),
      .done    (done),
      .hi      (hi),
      .lo      (lo)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   initial cyc = 0;
   always @(posedge clock) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Monitor: every done pulse must match the oldest outstanding expectation.
   always @(negedge clock) begin
      if (reset_n === 1'b1 && done === 1'b1) begin
         if (sb.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_done: got done=1 expected no pending result (cycle %0d)", cyc);
         end else begin
            exp_t e;
            e = sb.pop_front();
            chk("hi", hi, e.hi);
            chk("lo", lo, e.lo);
            chk("latency", 32'(cyc), 32'(e.due));
            chk("busy_in_done", {31'd0, busy}, 32'd0);
         end
      end
   end

   task automatic issue(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y,
                        input logic [31:0] eh, input logic [31:0] el);
      exp_t e;
      start = 1'b1;
      op    = o;
      a     = x;
      b     = y;
      e.hi  = eh;
      e.lo  = el;
      e.due = cyc + 34;
      sb.push_back(e);
      @(negedge clock);
      #1;
      start = 1'b0;
      op    = 2'($urandom);
      a     = $urandom;
      b     = $urandom;
   endtask

   task automatic wait_done(input string tag);
      int n;
      n = 0;
      while (sb.size() != 0 && n < 45) begin
         @(negedge clock);
         #1;
         n++;
      end
      checks++;
      if (sb.size() != 0) begin
         errors++;
         $display("FAIL timeout_%s: got %0d pending results expected 0", tag, sb.size());
         sb.delete();
      end
   endtask

   initial begin
      #500000;
      $display("FAIL global_timeout: got no finish expected finish");
      $fatal(1, "bench timeout");
   end

   initial begin
      checks  = 0;
      errors  = 0;
      reset_n = 1'b0;
      start   = 1'b0;
      op      = 2'b00;
      a       = 32'd0;
      b       = 32'd0;
      repeat (3) @(negedge clock);
      #1;
      chk("reset_busy", {31'd0, busy}, 32'd0);
      chk("reset_done", {31'd0, done}, 32'd0);
      chk("reset_hi", hi, 32'd0);
      chk("reset_lo", lo, 32'd0);
      reset_n = 1'b1;
      @(negedge clock);
      #1;

      issue(OP_MULT, 32'd7, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'hFFFF_FFEB);
      wait_done("mult");
      issue(OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001);
      wait_done("multu");
      issue(OP_DIV, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
      wait_done("div");
      issue(OP_DIVU, 32'd100, 32'd0, 32'h0000_0064, 32'hFFFF_FFFF);
      wait_done("divu_zero");
      issue(OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000);
      wait_done("div_ovf");
      issue(OP_DIV, 32'hFFFF_FFF9, 32'd0, 32'hFFFF_FFF9, 32'hFFFF_FFFF);
      wait_done("div_zero");

      // Start while busy is ignored; HI/LO keep the previous result meanwhile.
      issue(OP_DIVU, 32'd10, 32'd3, 32'd1, 32'd3);
      repeat (9) begin
         @(negedge clock);
         #1;
      end
      chk("busy_mid_op", {31'd0, busy}, 32'd1);
      chk("hold_hi", hi, 32'hFFFF_FFF9);
      chk("hold_lo", lo, 32'hFFFF_FFFF);
      start = 1'b1;
      op    = OP_MULT;
      a     = 32'd5;
      b     = 32'd5;
      @(negedge clock);
      #1;
      start = 1'b0;
      begin
         int n;
         n = 0;
         while (done !== 1'b1 && n < 45) begin
            @(negedge clock);
            #1;
            n++;
         end
      end
      // Back-to-back: issue during the done cycle.
      issue(OP_MULT, 32'd5, 32'd5, 32'd0, 32'd25);
      wait_done("b2b");

      // Asynchronous reset in the middle of a multiply.
      issue(OP_MULT, 32'd1234, 32'd5678, 32'd0, 32'd7006652);
      repeat (14) begin
         @(negedge clock);
         #1;
      end
      #1;
      reset_n = 1'b0;
      #1;
      chk("areset_busy", {31'd0, busy}, 32'd0);
      chk("areset_done", {31'd0, done}, 32'd0);
      chk("areset_hi", hi, 32'd0);
      chk("areset_lo", lo, 32'd0);
      sb.delete();
      @(negedge clock);
      #2;
      reset_n = 1'b1;
      repeat (30) begin
         @(negedge clock);
         #1;
      end
      issue(OP_DIVU, 32'd9, 32'd4, 32'd1, 32'd2);
      wait_done("divu_after_reset");
      repeat (3) @(negedge clock);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/mult_div_unit.md
# mult_div_unit

Iterative 32-bit multiply/divide unit in the execute stage, directly downstream of the register bank's two read ports. Operands arrive from readA/readB. The unit runs a fixed-latency multi-cycle shift-add multiply or restoring divide and holds a 64-bit HI/LO result. The control unit then routes that result back to the bank's write port.

## Interface
- No parameters; data width fixed at 32.
- clock  input  1  system clock; all state updates on rising edge
- reset_n  input  1  asynchronous, active-low reset
- start  input  1  request a new operation; sampled on rising edge
- op  input  2  00 MULT (signed), 01 MULTU, 10 DIV (signed), 11 DIVU; sampled with start
- a  input  32  operand A (multiplicand / dividend), from bank readA; sampled with start
- b  input  32  operand B (multiplier / divisor), from bank readB; sampled with start
- busy  output  1  operation in progress; start ignored while high
- done  output  1  one-cycle pulse: hi/lo hold the new result
- hi  output  32  product[63:32] or remainder
- lo  output  32  product[31:0] or quotient

## Operation
- States: IDLE, CALC, FIX, DONE.
- IDLE/DONE with start=1:
  - Latch op.
  - Signed ops convert a and b to magnitudes; record the result sign (a[31]^b[31]) and the remainder sign (a[31]).
  - Clear the 64-bit accumulator; iteration counter = 0.
  - Go to CALC.
- CALC, multiply: each edge examines one multiplier bit, LSB first. If the bit is 1, add the multiplicand into the upper half with carry. Then shift the accumulator right by 1.
- CALC, divide: each edge performs one restoring step on {remainder, quotient}: shift left 1, trial-subtract the divisor magnitude, keep the result if non-negative and set the quotient LSB, else restore.
- The counter increments each CALC edge. At count 31 the 32nd iteration completes and the state goes to FIX.
- FIX:
  - MULT: negate the 64-bit product if the sign flag is set.
  - DIV: negate the quotient if the sign flag is set; negate the remainder if a was negative.
  - Write hi/lo; go to DONE.
- DONE: done=1 for exactly one cycle. Next state is IDLE, or CALC if start=1 (back-to-back accepted).
- Divide by zero (b==0), DIV or DIVU: lo=0xFFFFFFFF, hi=a as supplied (unsigned or signed, unnegated). The same 33-cycle latency applies; no exception output.
- DIV 0x80000000 / 0xFFFFFFFF: lo=0x80000000, hi=0 (natural wrap, no flag).
- hi/lo change only on the FIX edge. They hold the previous result through a new operation until its FIX.
- start while busy=1: ignored; no queueing.

## Timing
- Reset (async assert, any state): state=IDLE, busy=0, done=0, hi=0, lo=0, counter=0. An in-flight operation is discarded with no done pulse.
- Start accepted at edge E0.
- busy=1 from after E0 through E33 (CALC edges E1..E32, FIX edge E33).
- done=1 and the result valid in the cycle after E33, i.e. 33 cycles after start. busy=0 in that cycle.
- Next accepted start: the earliest is E34, while done is high.
- Operands are needed only at E0. The bank may be rewritten during CALC without effect.
- The bank writes on negedge, so a result routed back by the control unit in the done cycle lands at the following falling edge.

## Test plan
- Reset, then MULT a=7, b=0xFFFFFFFD (-3) -> after 33 cycles done=1 for one cycle, hi=0xFFFFFFFF, lo=0xFFFFFFEB, busy low.
- MULTU a=b=0xFFFFFFFF -> hi=0xFFFFFFFE, lo=0x00000001.
- DIV a=0xFFFFFFF9 (-7), b=2 -> lo=0xFFFFFFFD (-3), hi=0xFFFFFFFF (-1).
- DIVU a=100, b=0 -> lo=0xFFFFFFFF, hi=0x00000064.
- Checks on one run: start DIVU 10/3, then pulse start with MULT 5*5 at cycle 10 -> ignored, result lo=3, hi=1. Re-issue MULT 5*5 on the done cycle -> lo=25, hi=0, 33 cycles later.
- Assert reset_n=0 asynchronously at cycle 15 of a MULT, release -> hi=lo=0, busy=0, no done pulse. A new DIVU 9/4 completes normally: lo=2, hi=1.
